dma_read_arbiter: RTL and testbench
===================================

# dma_read_arbiter

Shares the single AHB-Lite read master port between two DMA read requesters (requester 0: the verifier's DMA_READ/DMA_READ_addr pulse; requester 1: a second reader such as a descriptor fetcher). Each single-cycle request pulse is latched, arbitrated round-robin, and issued as one single-word AHB-Lite read. The returned word is delivered on a shared data bus with a per-requester valid pulse. The block sits between the requesters and the AHB-Lite interconnect.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- CLK  in  1  clock; all logic on rising edge
- RESETn  in  1  reset; synchronous, active-low
- i_req  in  2  single-cycle read request pulse, bit i = requester i
- i_req_addr0  in  ADDR_W  requester 0 word address, sampled with i_req[0]
- i_req_addr1  in  ADDR_W  requester 1 word address, sampled with i_req[1]
- o_rdata  out  DATA_W  read data, valid only with an o_rvalid bit
- o_rvalid  out  2  one-cycle data-return pulse per requester
- o_err  out  2  one-cycle error pulse per requester (HRESP=1 at completion)
- o_pending  out  2  request latched and not yet completed
- o_overflow  out  2  sticky: pulse dropped while already pending
- HADDR  out  ADDR_W  AHB address
- HTRANS  out  2  IDLE=2'b00 or NONSEQ=2'b10 only
- HWRITE  out  1  tied 0
- HSIZE  out  3  tied 3'b010 (word)
- HBURST  out  3  tied 3'b000 (SINGLE)
- HREADY  in  1  transfer ready
- HRESP  in  1  error response
- HRDATA  in  DATA_W  read data

## Operation
- Per requester: a pending flag and an address register. On i_req[i] with pending clear, set pending and capture the address. On i_req[i] with pending set, ignore the pulse and set o_overflow[i].
- Exception: a pulse in the same cycle that requester i's transfer completes is accepted. Pending stays set, the new address is captured, and o_overflow is not set.
- Round-robin: register last_grant, reset value 1, so requester 0 wins first. If both requesters are pending, grant = !last_grant. If one is pending, grant goes to that requester. last_grant updates at completion.
- FSM ARB_IDLE: if any pending, set grant, register HADDR = grant address and HTRANS = NONSEQ, then go to ARB_ADDR. Otherwise HTRANS = IDLE.
- FSM ARB_ADDR: hold HADDR and HTRANS while HREADY=0. When HREADY=1, set HTRANS <= IDLE and go to ARB_DATA.
- FSM ARB_DATA: wait while HREADY=0. When HREADY=1:
  - If HRESP=0: o_rdata <= HRDATA, pulse o_rvalid[grant].
  - If HRESP=1: pulse o_err[grant]; o_rdata holds its old value.
  - In both cases clear pending[grant] and return to ARB_IDLE.
- Only one transfer is outstanding at a time; there is no address/data pipelining.
- Reset values:
  - HTRANS, HADDR, o_rdata, o_rvalid, o_err, o_pending, o_overflow all 0.
  - State ARB_IDLE, last_grant 1.
  - Pulses arriving during reset are lost.
- Reset mid-transfer: the bus returns to IDLE on the next edge and all pending requests are discarded.

## Timing
- Zero-wait-state latency: i_req pulse sampled at edge E0 → pending set at E0.
  - E1: HTRANS = NONSEQ.
  - E2: address accepted.
  - E3: o_rvalid high for one cycle after E3.
  - Request-to-data latency is therefore 3 cycles.
- Each HREADY=0 cycle in ARB_ADDR or ARB_DATA adds exactly 1 cycle.
- Back-to-back throughput is 1 transfer per 3 cycles (one ARB_IDLE cycle between transfers).
- o_rvalid and o_err are never both set, and never set for both requesters in the same cycle.
- o_pending updates the cycle after the pulse or completion.

## Structure
- Shared package dma_arb_pkg contains:
  - typedef enum arb_state_t {ARB_IDLE, ARB_ADDR, ARB_DATA}
  - constants HTRANS_IDLE, HTRANS_NONSEQ, HSIZE_WORD, HBURST_SINGLE
- Sub-module dma_req_slot, instantiated twice. It holds the pending flag, address register and overflow flag. Inputs: pulse, address, complete. Outputs: pending, addr, overflow.
- The top level holds the FSM, last_grant and the AHB/return registers.

## Test plan
- Single request: i_req=2'b01, addr 0x0000_1000, slave returns 0xDEADBEEF with no waits → HADDR=0x1000 NONSEQ at E1, o_rvalid=2'b01 with o_rdata=0xDEADBEEF after E3, o_pending back to 0.
- Simultaneous requests: i_req=2'b11, addr0=0x100, addr1=0x200 → first transfer to 0x100 (rvalid 01), then 0x200 (rvalid 10). A repeat of both requests → 0x100 first again, because last_grant alternates.
- Wait states: HREADY low for 2 cycles in ARB_ADDR and 3 in ARB_DATA → HADDR and HTRANS stable while stalled, o_rvalid 8 cycles after the pulse.
- Overflow: i_req[0] pulsed twice 1 cycle apart → one transfer at the first address, o_overflow[0]=1 and sticky until RESETn=0.
- Error: HRESP=1 with HREADY=1 in ARB_DATA → o_err[grant] pulse, no o_rvalid, o_rdata unchanged, pending cleared.
- Reset mid-transfer: RESETn=0 during ARB_DATA with both requesters pending → next edge HTRANS=IDLE, all outputs 0, no rvalid afterwards until a new pulse.

Source files
------------

// File: rtl/dma_arb_pkg.sv
// Shared types and AHB-Lite encodings for the DMA read arbiter.
package dma_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ADDR,
        ARB_DATA
    } arb_state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

endpackage

// File: rtl/dma_req_slot.sv
// One requester's latch: pending flag, captured address and sticky overflow.
// A pulse arriving in the cycle this slot's transfer completes is accepted
// as a fresh request rather than counted as an overflow.
module dma_req_slot #(
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              pulse,
    input  logic [ADDR_W-1:0] address,
    input  logic              complete,
    output logic              pending,
    output logic [ADDR_W-1:0] addr,
    output logic              overflow
);

    logic accept;

    assign accept = pulse && (!pending || complete);

    // Latch new requests, retire completed ones, flag dropped pulses.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            pending  <= 1'b0;
            addr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                pending <= 1'b1;
                addr    <= address;
            end else if (complete) begin
                pending <= 1'b0;
            end
            if (pulse && pending && !complete) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_read_arbiter.sv
// Round-robin arbiter sharing one AHB-Lite read master between two DMA
// requesters. One single-word transfer is in flight at a time.
module dma_read_arbiter
    import dma_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic [1:0]        i_req,
    input  logic [ADDR_W-1:0] i_req_addr0,
    input  logic [ADDR_W-1:0] i_req_addr1,
    output logic [DATA_W-1:0] o_rdata,
    output logic [1:0]        o_rvalid,
    output logic [1:0]        o_err,
    output logic [1:0]        o_pending,
    output logic [1:0]        o_overflow,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    input  logic              HREADY,
    input  logic              HRESP,
    input  logic [DATA_W-1:0] HRDATA
);

    arb_state_t        state, state_next;
    logic              grant, grant_sel, last_grant;
    logic              start, addr_done, xfer_done;
    logic [1:0]        complete;
    logic [ADDR_W-1:0] slot_addr0, slot_addr1;

    assign HWRITE   = 1'b0;
    assign HSIZE    = HSIZE_WORD;
    assign HBURST   = HBURST_SINGLE;
    assign complete = {xfer_done && grant, xfer_done && !grant};

    dma_req_slot #(.ADDR_W(ADDR_W)) u_slot0 (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .pulse    (i_req[0]),
        .address  (i_req_addr0),
        .complete (complete[0]),
        .pending  (o_pending[0]),
        .addr     (slot_addr0),
        .overflow (o_overflow[0])
    );

    dma_req_slot #(.ADDR_W(ADDR_W)) u_slot1 (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .pulse    (i_req[1]),
        .address  (i_req_addr1),
        .complete (complete[1]),
        .pending  (o_pending[1]),
        .addr     (slot_addr1),
        .overflow (o_overflow[1])
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, round-robin pick and phase strobes.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        addr_done  = 1'b0;
        xfer_done  = 1'b0;
        if (o_pending == 2'b11) begin
            grant_sel = !last_grant;
        end else begin
            grant_sel = !o_pending[0];
        end
        case (state)
            ARB_IDLE: begin
                if (|o_pending) begin
                    start      = 1'b1;
                    state_next = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                if (HREADY) begin
                    addr_done  = 1'b1;
                    state_next = ARB_DATA;
                end
            end
            ARB_DATA: begin
                if (HREADY) begin
                    xfer_done  = 1'b1;
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // AHB address-phase registers, grant history and data-return pulses.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            HADDR      <= '0;
            HTRANS     <= HTRANS_IDLE;
            o_rdata    <= '0;
            o_rvalid   <= 2'b00;
            o_err      <= 2'b00;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            o_rvalid <= 2'b00;
            o_err    <= 2'b00;
            if (start) begin
                grant  <= grant_sel;
                HADDR  <= grant_sel ? slot_addr1 : slot_addr0;
                HTRANS <= HTRANS_NONSEQ;
            end
            if (addr_done) begin
                HTRANS <= HTRANS_IDLE;
            end
            if (xfer_done) begin
                last_grant <= grant;
                if (HRESP) begin
                    o_err[grant] <= 1'b1;
                end else begin
                    o_rdata         <= HRDATA;
                    o_rvalid[grant] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dma_read_arbiter.sv
// Directed self-checking bench for dma_read_arbiter; the bench plays the
// AHB slave by driving HREADY/HRESP/HRDATA cycle by cycle.
module tb_dma_read_arbiter;

    logic        CLK;
    logic        RESETn;
    logic [1:0]  i_req;
    logic [31:0] i_req_addr0, i_req_addr1;
    logic [31:0] o_rdata;
    logic [1:0]  o_rvalid, o_err, o_pending, o_overflow;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE, HBURST;
    logic        HREADY, HRESP;
    logic [31:0] HRDATA;

    int n_cmp  = 0;
    int n_fail = 0;

    dma_read_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .CLK         (CLK),
        .RESETn      (RESETn),
        .i_req       (i_req),
        .i_req_addr0 (i_req_addr0),
        .i_req_addr1 (i_req_addr1),
        .o_rdata     (o_rdata),
        .o_rvalid    (o_rvalid),
        .o_err       (o_err),
        .o_pending   (o_pending),
        .o_overflow  (o_overflow),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HSIZE       (HSIZE),
        .HBURST      (HBURST),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .HRDATA      (HRDATA)
    );

    // Free-running clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESETn = 1'b0;
        i_req = 2'b11;
        i_req_addr0 = 32'hAAAA_0000;
        i_req_addr1 = 32'hBBBB_0000;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
        tick();
        tick();
        n_cmp++; if (HTRANS !== 2'b00) begin n_fail++; $display("[TB] FAIL rst_htrans: got %b want 00", HTRANS); end
        n_cmp++; if (HADDR !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_haddr: got %h want 0", HADDR); end
        n_cmp++; if ({o_rvalid, o_err, o_pending, o_overflow} !== 8'h00) begin n_fail++; $display("[TB] FAIL rst_flags: got %h want 00", {o_rvalid, o_err, o_pending, o_overflow}); end
        n_cmp++; if (o_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_rdata: got %h want 0", o_rdata); end
        n_cmp++; if ({HWRITE, HSIZE, HBURST} !== 7'b0_010_000) begin n_fail++; $display("[TB] FAIL rst_tied: got %b want 0010000", {HWRITE, HSIZE, HBURST}); end
        RESETn = 1'b1;
        i_req = 2'b00;
        tick();
        n_cmp++; if (o_pending !== 2'b00) begin n_fail++; $display("[TB] FAIL rst_lost_pulse: got %b want 00", o_pending); end
        n_cmp++; if (HTRANS !== 2'b00) begin n_fail++; $display("[TB] FAIL rst_idle_after: got %b want 00", HTRANS); end
    endtask

    task automatic test_simultaneous();
        for (int rep = 0; rep < 2; rep++) begin
            i_req = 2'b11;
            i_req_addr0 = 32'h100;
            i_req_addr1 = 32'h200;
            tick();
            i_req = 2'b00;
            n_cmp++; if (o_pending !== 2'b11) begin n_fail++; $display("[TB] FAIL sim_pending%0d: got %b want 11", rep, o_pending); end
            tick();
            n_cmp++; if (HADDR !== 32'h100 || HTRANS !== 2'b10) begin n_fail++; $display("[TB] FAIL sim_first_addr%0d: got %h/%b want 00000100/10", rep, HADDR, HTRANS); end
            tick();
            HRDATA = 32'hA1A1_0000 + rep;
            tick();
            n_cmp++; if (o_rvalid !== 2'b01 || o_rdata !== 32'hA1A1_0000 + rep) begin n_fail++; $display("[TB] FAIL sim_first_data%0d: got %b/%h want 01/%h", rep, o_rvalid, o_rdata, 32'hA1A1_0000 + rep); end
            n_cmp++; if (o_pending !== 2'b10) begin n_fail++; $display("[TB] FAIL sim_pending_mid%0d: got %b want 10", rep, o_pending); end
            tick();
            n_cmp++; if (HADDR !== 32'h200 || HTRANS !== 2'b10) begin n_fail++; $display("[TB] FAIL sim_second_addr%0d: got %h/%b want 00000200/10", rep, HADDR, HTRANS); end
            tick();
            HRDATA = 32'hB2B2_0000 + rep;
            tick();
            n_cmp++; if (o_rvalid !== 2'b10 || o_rdata !== 32'hB2B2_0000 + rep) begin n_fail++; $display("[TB] FAIL sim_second_data%0d: got %b/%h want 10/%h", rep, o_rvalid, o_rdata, 32'hB2B2_0000 + rep); end
            n_cmp++; if (o_pending !== 2'b00) begin n_fail++; $display("[TB] FAIL sim_pending_end%0d: got %b want 00", rep, o_pending); end
            tick();
        end
    endtask

    task automatic test_single();
        i_req = 2'b01;
        i_req_addr0 = 32'h0000_1000;
        tick();
        i_req = 2'b00;
        n_cmp++; if (o_pending !== 2'b01 || HTRANS !== 2'b00) begin n_fail++; $display("[TB] FAIL single_e0: got %b/%b want 01/00", o_pending, HTRANS); end
        tick();
        n_cmp++; if (HADDR !== 32'h1000 || HTRANS !== 2'b10) begin n_fail++; $display("[TB] FAIL single_e1: got %h/%b want 00001000/10", HADDR, HTRANS); end
        HRDATA = 32'hDEAD_BEEF;
        tick();
        n_cmp++; if (HTRANS !== 2'b00 || o_rvalid !== 2'b00) begin n_fail++; $display("[TB] FAIL single_e2: got %b/%b want 00/00", HTRANS, o_rvalid); end
        tick();
        n_cmp++; if (o_rvalid !== 2'b01 || o_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL single_e3: got %b/%h want 01/deadbeef", o_rvalid, o_rdata); end
        n_cmp++; if (o_pending !== 2'b00) begin n_fail++; $display("[TB] FAIL single_pending: got %b want 00", o_pending); end
        tick();
        n_cmp++; if (o_rvalid !== 2'b00) begin n_fail++; $display("[TB] FAIL single_pulse_len: got %b want 00", o_rvalid); end
    endtask

    task automatic test_wait_states();
        i_req = 2'b01;
        i_req_addr0 = 32'h0000_2000;
        tick();
        i_req = 2'b00;
        tick();
        HREADY = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_cmp++; if (HADDR !== 32'h2000 || HTRANS !== 2'b10) begin n_fail++; $display("[TB] FAIL ws_addr_hold%0d: got %h/%b want 00002000/10", k, HADDR, HTRANS); end
        end
        HREADY = 1'b1;
        tick();
        n_cmp++; if (HTRANS !== 2'b00) begin n_fail++; $display("[TB] FAIL ws_addr_accept: got %b want 00", HTRANS); end
        HREADY = 1'b0;
        HRDATA = 32'h1234_5678;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (o_rvalid !== 2'b00) begin n_fail++; $display("[TB] FAIL ws_data_hold%0d: got %b want 00", k, o_rvalid); end
        end
        HREADY = 1'b1;
        tick();
        n_cmp++; if (o_rvalid !== 2'b01 || o_rdata !== 32'h1234_5678) begin n_fail++; $display("[TB] FAIL ws_data: got %b/%h want 01/12345678", o_rvalid, o_rdata); end
        tick();
    endtask

    task automatic test_overflow();
        i_req = 2'b01;
        i_req_addr0 = 32'h0000_3000;
        tick();
        i_req = 2'b00;
        tick();
        n_cmp++; if (HADDR !== 32'h3000) begin n_fail++; $display("[TB] FAIL ovf_addr: got %h want 00003000", HADDR); end
        i_req = 2'b01;
        i_req_addr0 = 32'h0000_3004;
        tick();
        i_req = 2'b00;
        n_cmp++; if (o_overflow !== 2'b01) begin n_fail++; $display("[TB] FAIL ovf_flag: got %b want 01", o_overflow); end
        HRDATA = 32'h0000_3333;
        tick();
        n_cmp++; if (o_rvalid !== 2'b01 || o_pending !== 2'b00) begin n_fail++; $display("[TB] FAIL ovf_done: got %b/%b want 01/00", o_rvalid, o_pending); end
        tick();
        tick();
        n_cmp++; if (HTRANS !== 2'b00 || o_overflow !== 2'b01) begin n_fail++; $display("[TB] FAIL ovf_sticky: got %b/%b want 00/01", HTRANS, o_overflow); end
    endtask

    task automatic test_complete_repulse();
        i_req = 2'b10;
        i_req_addr1 = 32'h0000_0500;
        tick();
        i_req = 2'b00;
        tick();
        tick();
        HRDATA = 32'h0000_5555;
        i_req = 2'b10;
        i_req_addr1 = 32'h0000_0600;
        tick();
        i_req = 2'b00;
        n_cmp++; if (o_rvalid !== 2'b10 || o_pending !== 2'b10 || o_overflow !== 2'b01) begin n_fail++; $display("[TB] FAIL rep_complete: got %b/%b/%b want 10/10/01", o_rvalid, o_pending, o_overflow); end
        tick();
        n_cmp++; if (HADDR !== 32'h600 || HTRANS !== 2'b10) begin n_fail++; $display("[TB] FAIL rep_addr: got %h/%b want 00000600/10", HADDR, HTRANS); end
        tick();
        HRDATA = 32'h0000_6666;
        tick();
        n_cmp++; if (o_rvalid !== 2'b10 || o_rdata !== 32'h6666) begin n_fail++; $display("[TB] FAIL rep_data: got %b/%h want 10/00006666", o_rvalid, o_rdata); end
        tick();
    endtask

    task automatic test_error();
        i_req = 2'b01;
        i_req_addr0 = 32'h0000_4000;
        tick();
        i_req = 2'b00;
        tick();
        tick();
        HRESP = 1'b1;
        HRDATA = 32'hBAD0_BAD0;
        tick();
        HRESP = 1'b0;
        n_cmp++; if (o_err !== 2'b01 || o_rvalid !== 2'b00) begin n_fail++; $display("[TB] FAIL err_pulse: got %b/%b want 01/00", o_err, o_rvalid); end
        n_cmp++; if (o_rdata !== 32'h6666 || o_pending !== 2'b00) begin n_fail++; $display("[TB] FAIL err_hold: got %h/%b want 00006666/00", o_rdata, o_pending); end
        tick();
        n_cmp++; if (o_err !== 2'b00) begin n_fail++; $display("[TB] FAIL err_pulse_len: got %b want 00", o_err); end
    endtask

    task automatic test_reset_mid();
        i_req = 2'b11;
        i_req_addr0 = 32'h700;
        i_req_addr1 = 32'h800;
        tick();
        i_req = 2'b00;
        tick();
        tick();
        HREADY = 1'b0;
        tick();
        RESETn = 1'b0;
        tick();
        n_cmp++; if (HTRANS !== 2'b00 || HADDR !== 32'h0) begin n_fail++; $display("[TB] FAIL midrst_bus: got %b/%h want 00/00000000", HTRANS, HADDR); end
        n_cmp++; if ({o_rvalid, o_err, o_pending, o_overflow} !== 8'h00 || o_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL midrst_outs: got %h/%h want 00/00000000", {o_rvalid, o_err, o_pending, o_overflow}, o_rdata); end
        RESETn = 1'b1;
        HREADY = 1'b1;
        HRDATA = 32'hFFFF_FFFF;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++; if (o_rvalid !== 2'b00 || HTRANS !== 2'b00) begin n_fail++; $display("[TB] FAIL midrst_quiet%0d: got %b/%b want 00/00", k, o_rvalid, HTRANS); end
        end
    endtask

    // Scenario sequence; round-robin history carries from one test to the next.
    initial begin
        test_reset();
        test_simultaneous();
        test_single();
        test_wait_states();
        test_overflow();
        test_complete_repulse();
        test_error();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
